// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle for sync_fifo_ctrl.
// FIFO_PARITY_EN adds the rperr/parity_err signals.
interface sync_fifo_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;
`ifdef FIFO_PARITY_EN
  logic                rperr;
  logic                parity_err;
`endif

  modport master (
    output winc, wdata, rinc,
    input  rdata, rvalid, wfull, rempty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
`ifdef FIFO_PARITY_EN
    , input rperr, parity_err
`endif
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, rvalid, wfull, rempty,
    output almost_full, almost_empty,
    output count, overflow, underflow
`ifdef FIFO_PARITY_EN
    , output rperr, parity_err
`endif
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered read, level flags, sticky errors.
// Optional FIFO_PARITY_EN stores an even-parity bit per word.
module sync_fifo_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int AF_LEVEL = (1 << ADDRSIZE) - 4,
  parameter int AE_LEVEL = 2
) (
  input logic             wclk,
  input logic             wrst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;
`ifdef FIFO_PARITY_EN
  localparam int MW = DATASIZE + 1;
`else
  localparam int MW = DATASIZE;
`endif

  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_bad
      $fatal(1, "sync_fifo_ctrl: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_bad
      $fatal(1, "sync_fifo_ctrl: AE_LEVEL out of range");
    end
  endgenerate

  logic [MW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [PW-1:0]       cnt;
  logic [DATASIZE-1:0] rdata_q;
  logic                rvalid_q;
  logic                ovf_q;
  logic                unf_q;
  logic                full;
  logic                empty;
  logic                wr_ok;
  logic                rd_ok;
  logic [MW-1:0]       wword;
  logic [MW-1:0]       rword;
  logic                unused_msb;

  // Flags decode straight from the occupancy register.
  always_comb begin
    full  = (cnt == PW'(DEPTH));
    empty = (cnt == '0);
    wr_ok = bus.winc && !full;
    rd_ok = bus.rinc && !empty;
  end

  // Pointer MSBs are kept for a uniform binary width only.
  assign unused_msb = wptr[PW-1] ^ rptr[PW-1];

`ifdef FIFO_PARITY_EN
  assign wword = {^bus.wdata, bus.wdata};
`else
  assign wword = bus.wdata;
`endif
  assign rword = mem[rptr[ADDRSIZE-1:0]];

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge wclk) begin
    if (!wrst && wr_ok) begin
      mem[wptr[ADDRSIZE-1:0]] <= wword;
    end
  end

  // Pointers and occupancy; both-accepted leaves count unchanged.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered read port; rdata holds between accepted reads.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_ok;
      if (rd_ok) rdata_q <= rword[DATASIZE-1:0];
    end
  end

  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.winc && full)  ovf_q <= 1'b1;
      if (bus.rinc && empty) unf_q <= 1'b1;
    end
  end

`ifdef FIFO_PARITY_EN
  logic rperr_q;
  logic perr_q;

  // Recheck stored parity on each accepted read.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      rperr_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      rperr_q <= rd_ok && (^rword);
      if (rd_ok && (^rword)) perr_q <= 1'b1;
    end
  end

  assign bus.rperr      = rperr_q;
  assign bus.parity_err = perr_q;
`endif

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.wfull        = full;
  assign bus.rempty       = empty;
  assign bus.almost_full  = (cnt >= PW'(AF_LEVEL));
  assign bus.almost_empty = (cnt <= PW'(AE_LEVEL));
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: directed steps plus random traffic,
// checked against a queue-based model of the FIFO rules.
module tb_sync_fifo_ctrl;
  localparam int DS  = 8;
  localparam int AS  = 4;
  localparam int DEP = 16;
  localparam int AF  = 12;
  localparam int AE  = 2;

  logic wclk;
  logic wrst;
  int   checks;
  int   failures;

  sync_fifo_ctrl_if #(.DATASIZE(DS), .ADDRSIZE(AS)) bus ();

  sync_fifo_ctrl #(
    .DATASIZE(DS),
    .ADDRSIZE(AS),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .wclk(wclk),
    .wrst(wrst),
    .bus (bus.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic [DS-1:0] q[$];
  bit            bad[$];
  logic [DS-1:0] m_rdata;
  bit            m_rvalid;
  bit            m_ovf;
  bit            m_unf;
  bit            m_rperr;
  bit            m_perr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(bus.count), 32'(n));
    chk("wfull", 32'(bus.wfull), 32'(n == DEP));
    chk("rempty", 32'(bus.rempty), 32'(n == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    chk("rdata", 32'(bus.rdata), 32'(m_rdata));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
`ifdef FIFO_PARITY_EN
    chk("rperr", 32'(bus.rperr), 32'(m_rperr));
    chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
`endif
  endtask

  // One clock: drive, clock, update model from pre-edge state, check.
  task automatic step(input bit w, input logic [DS-1:0] d,
                      input bit r, input bit rs);
    bit full;
    bit empty;
    bit b;
    wrst      = rs;
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = r;
    @(posedge wclk);
    #1;
    full  = (q.size() == DEP);
    empty = (q.size() == 0);
    if (rs) begin
      q.delete();
      bad.delete();
      m_rdata  = '0;
      m_rvalid = 0;
      m_ovf    = 0;
      m_unf    = 0;
      m_rperr  = 0;
      m_perr   = 0;
    end else begin
      if (w && full)  m_ovf = 1;
      if (r && empty) m_unf = 1;
      m_rvalid = r && !empty;
      m_rperr  = 0;
      if (r && !empty) begin
        m_rdata = q.pop_front();
        b = bad.pop_front();
        m_rperr = b;
        if (b) m_perr = 1;
      end
      if (w && !full) begin
        q.push_back(d);
        bad.push_back(1'b0);
      end
    end
    check_all();
  endtask

  logic [DS-1:0] v;

  initial begin
    checks   = 0;
    failures = 0;
    m_rdata  = '0;
    wrst      = 1'b1;
    bus.winc  = 1'b0;
    bus.wdata = '0;
    bus.rinc  = 1'b0;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("idle_rdata", 32'(bus.rdata), 32'h0);

    for (int i = 1; i <= 16; i++) step(1, DS'(i), 0, 0);
    chk("full_after_16", 32'(bus.wfull), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("last_read", 32'(bus.rdata), 32'h10);

    for (int i = 1; i <= 16; i++) step(1, DS'(8'h20 + i), 0, 0);
    step(1, 8'hEE, 1, 0);
    chk("full_rw_count", 32'(bus.count), 32'd15);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0);

    step(1, 8'hA5, 1, 0);
    chk("empty_rw_unf", 32'(bus.underflow), 32'd1);
    step(0, 0, 1, 0);
    chk("bypass_none", 32'(bus.rdata), 32'hA5);

    for (int i = 0; i < 8; i++) step(1, DS'(8'h40 + i), 0, 0);
    for (int i = 0; i < 40; i++) step(1, DS'(8'h48 + i), 1, 0);
    chk("wrap_count", 32'(bus.count), 32'd8);

    step(1, 8'h77, 0, 0);
    step(1, 8'h78, 1, 1);
    step(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      v = DS'($urandom);
      step(bit'($urandom_range(0, 1)), v,
           bit'($urandom_range(0, 1)),
           ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 20; i++) step(1, DS'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0);

`ifdef FIFO_PARITY_EN
    step(0, 0, 0, 1);
    step(1, 8'h3C, 0, 0);
    dut.mem[0][DS] = ~dut.mem[0][DS];
    bad[0] = 1'b1;
    step(0, 0, 1, 0);
    chk("rperr_pulse", 32'(bus.rperr), 32'd1);
    step(0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
